// File: rtl/ring_phase_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ring_phase_checker_pkg
// Brief   : Shared FSM state and fault-code encodings for the ring phase checker.
// Revision: 1.0 - initial release
// ============================================================================
package ring_phase_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [1:0] c_ERR_NONE   = 2'b00;
  localparam logic [1:0] c_ERR_ONEHOT = 2'b01;
  localparam logic [1:0] c_ERR_SKIP   = 2'b10;
  localparam logic [1:0] c_ERR_STALL  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/ring_phase_checker_onehot_enc.sv
`default_nettype none
// ============================================================================
// Module  : ring_phase_checker_onehot_enc
// Brief   : Combinational one-hot legality check and bit-index encoder.
// Revision: 1.0 - initial release
// ============================================================================
module ring_phase_checker_onehot_enc #(
  parameter int unsigned N_PHASE = 4
) (
  input  logic [N_PHASE-1:0]         phase,
  output logic                       is_onehot,
  output logic [$clog2(N_PHASE)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(N_PHASE);
  localparam int unsigned CNT_W = $clog2(N_PHASE + 1);

  logic [CNT_W-1:0] w_cnt;

  // idx is only meaningful when exactly one bit is set
  always_comb begin
    w_cnt = '0;
    idx   = '0;
    for (int i = 0; i < int'(N_PHASE); i++) begin
      if (phase[i]) begin
        w_cnt = w_cnt + CNT_W'(1);
        idx   = idx | IDX_W'(i);
      end
    end
  end

  assign is_onehot = (w_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/ring_phase_checker.sv
`default_nettype none
// ============================================================================
// Module  : ring_phase_checker
// Brief   : Checks one-hot ring phase rotation, acquires lock, counts revolutions
//           and latches a sticky fault code.
// Revision: 1.0 - initial release
// ============================================================================
module ring_phase_checker
  import ring_phase_checker_pkg::*;
#(
  parameter int unsigned N_PHASE   = 4,
  parameter int unsigned LOCK_CNT  = 3,
  parameter int unsigned STALL_MAX = 8,
  parameter int unsigned REV_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PHASE-1:0]         phase_in,
  input  logic                       phase_valid,
  input  logic                       clr_err,
  output logic                       locked,
  output logic                       fault,
  output logic [1:0]                 err_code,
  output logic [$clog2(N_PHASE)-1:0] cur_idx,
  output logic                       rev_tick,
  output logic [REV_W-1:0]           rev_count
);

  localparam int unsigned IDX_W   = $clog2(N_PHASE);
  localparam int unsigned ACQ_W   = $clog2(LOCK_CNT + 1);
  localparam int unsigned STALL_W = $clog2(STALL_MAX + 2);
  localparam logic [IDX_W-1:0] c_IDX_MAX = IDX_W'(N_PHASE - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [ACQ_W-1:0]   r_acq;
  logic [STALL_W-1:0] r_stall;
  logic [REV_W-1:0]   r_rev_count;
  logic               r_rev_tick;
  logic               r_locked;
  logic               r_fault;
  logic [1:0]         r_err;

  logic               w_onehot;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_idx_succ;
  logic               w_wrap;
  logic               w_adv;
  logic               w_hold;
  logic [ACQ_W-1:0]   w_acq_next;
  logic [STALL_W-1:0] w_stall_next;

  ring_phase_checker_onehot_enc #(
    .N_PHASE (N_PHASE)
  ) u_enc (
    .phase     (phase_in),
    .is_onehot (w_onehot),
    .idx       (w_idx)
  );

  assign w_wrap       = (r_idx == c_IDX_MAX);
  assign w_idx_succ   = w_wrap ? '0 : r_idx + IDX_W'(1);
  assign w_adv        = (w_idx == w_idx_succ);
  assign w_hold       = (w_idx == r_idx);
  assign w_acq_next   = r_acq + ACQ_W'(1);
  assign w_stall_next = r_stall + STALL_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_acq       <= '0;
      r_stall     <= '0;
      r_rev_count <= '0;
      r_rev_tick  <= 1'b0;
      r_locked    <= 1'b0;
      r_fault     <= 1'b0;
      r_err       <= c_ERR_NONE;
    end else begin
      r_rev_tick <= 1'b0;
      if (r_state == ST_FAULT) begin
        // Phase samples are ignored here; only a clear leaves the fault
        if (clr_err) begin
          r_state <= ST_IDLE;
          r_fault <= 1'b0;
          r_err   <= c_ERR_NONE;
          r_acq   <= '0;
          r_stall <= '0;
        end
      end else if (phase_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (w_onehot) begin
              r_idx   <= w_idx;
              r_acq   <= '0;
              r_state <= ST_ACQUIRE;
            end
          end
          ST_ACQUIRE: begin
            if (!w_onehot) begin
              r_state <= ST_IDLE;
            end else if (w_adv) begin
              r_idx <= w_idx;
              r_acq <= w_acq_next;
              if (w_acq_next == ACQ_W'(LOCK_CNT)) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_stall  <= '0;
              end
            end else if (!w_hold) begin
              r_idx <= w_idx;
              r_acq <= '0;
            end
          end
          ST_LOCKED: begin
            if (!w_onehot) begin
              r_state  <= ST_FAULT;
              r_locked <= 1'b0;
              r_fault  <= 1'b1;
              r_err    <= c_ERR_ONEHOT;
            end else if (w_adv) begin
              r_idx   <= w_idx;
              r_stall <= '0;
              if (w_wrap) begin
                r_rev_count <= r_rev_count + REV_W'(1);
                r_rev_tick  <= 1'b1;
              end
            end else if (w_hold) begin
              if (w_stall_next > STALL_W'(STALL_MAX)) begin
                r_state  <= ST_FAULT;
                r_locked <= 1'b0;
                r_fault  <= 1'b1;
                r_err    <= c_ERR_STALL;
              end else begin
                r_stall <= w_stall_next;
              end
            end else begin
              r_state  <= ST_FAULT;
              r_locked <= 1'b0;
              r_fault  <= 1'b1;
              r_err    <= c_ERR_SKIP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign fault     = r_fault;
  assign err_code  = r_err;
  assign cur_idx   = r_idx;
  assign rev_tick  = r_rev_tick;
  assign rev_count = r_rev_count;

endmodule
`default_nettype wire

// File: tb/tb_ring_phase_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_ring_phase_checker
// Brief   : Directed vector bench for ring_phase_checker (plus a narrow-REV_W copy).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ring_phase_checker;

  typedef struct {
    logic       v;
    logic [3:0] ph;
    logic       clr;
    logic       lk;
    logic       ft;
    logic [1:0] err;
    logic [1:0] idx;
    logic       tick;
    int         rev;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  phase_in = 4'b0000;
  logic        phase_valid = 1'b0;
  logic        clr_err = 1'b0;

  logic        locked, fault, rev_tick;
  logic [1:0]  err_code, cur_idx;
  logic [15:0] rev_count;

  logic        locked_n, fault_n, rev_tick_n;
  logic [1:0]  err_code_n, cur_idx_n;
  logic [1:0]  rev_count_n;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ring_phase_checker u_dut (
    .clk         (clk),
    .rst         (rst),
    .phase_in    (phase_in),
    .phase_valid (phase_valid),
    .clr_err     (clr_err),
    .locked      (locked),
    .fault       (fault),
    .err_code    (err_code),
    .cur_idx     (cur_idx),
    .rev_tick    (rev_tick),
    .rev_count   (rev_count)
  );

  // Narrow revolution counter to exercise the silent wrap
  ring_phase_checker #(.REV_W(2)) u_dut_narrow (
    .clk         (clk),
    .rst         (rst),
    .phase_in    (phase_in),
    .phase_valid (phase_valid),
    .clr_err     (clr_err),
    .locked      (locked_n),
    .fault       (fault_n),
    .err_code    (err_code_n),
    .cur_idx     (cur_idx_n),
    .rev_tick    (rev_tick_n),
    .rev_count   (rev_count_n)
  );

  task automatic chk(input string name, input int n, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, n, got, exp);
    end
  endtask

  task automatic chk_all(input int n, input logic lk, input logic ft, input logic [1:0] err,
                         input logic [1:0] idx, input logic tick, input int rev);
    chk("locked",      n, 32'(locked),      32'(lk));
    chk("fault",       n, 32'(fault),       32'(ft));
    chk("err_code",    n, 32'(err_code),    32'(err));
    chk("cur_idx",     n, 32'(cur_idx),     32'(idx));
    chk("rev_tick",    n, 32'(rev_tick),    32'(tick));
    chk("rev_count",   n, 32'(rev_count),   32'(rev[15:0]));
    chk("rev_tick_w2", n, 32'(rev_tick_n),  32'(tick));
    chk("rev_cnt_w2",  n, 32'(rev_count_n), 32'(rev[1:0]));
  endtask

  task automatic add(input logic v, input logic [3:0] ph, input logic clr, input logic lk,
                     input logic ft, input logic [1:0] err, input logic [1:0] idx,
                     input logic tick, input int rev);
    vec_t t;
    t.v = v; t.ph = ph; t.clr = clr; t.lk = lk; t.ft = ft;
    t.err = err; t.idx = idx; t.tick = tick; t.rev = rev;
    vecs.push_back(t);
  endtask

  task automatic step(input logic v, input logic [3:0] ph, input logic clr);
    @(negedge clk);
    phase_valid = v;
    phase_in    = ph;
    clr_err     = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Lock acquisition with a valid gap
    add(1, 4'b0001, 0, 0, 0, 2'd0, 2'd0, 0, 0);
    add(1, 4'b0010, 0, 0, 0, 2'd0, 2'd1, 0, 0);
    add(0, 4'b0100, 0, 0, 0, 2'd0, 2'd1, 0, 0);
    add(1, 4'b0100, 0, 0, 0, 2'd0, 2'd2, 0, 0);
    add(1, 4'b1000, 0, 1, 0, 2'd0, 2'd3, 0, 0);
    // Three revolutions, tick on each wrap to phase 0
    for (int r = 1; r <= 3; r++)
      for (int k = 0; k < 4; k++)
        add(1, 4'(4'b0001 << k), 0, 1, 0, 2'd0, 2'(k), (k == 0), r);
    add(1, 4'b0001, 0, 1, 0, 2'd0, 2'd0, 1, 4);
    add(1, 4'b0010, 0, 1, 0, 2'd0, 2'd1, 0, 4);
    add(0, 4'b0000, 0, 1, 0, 2'd0, 2'd1, 0, 4);
    // Not-one-hot in LOCKED, sticky fault, clear beats a concurrent sample
    add(1, 4'b0110, 0, 0, 1, 2'd1, 2'd1, 0, 4);
    add(1, 4'b0100, 0, 0, 1, 2'd1, 2'd1, 0, 4);
    add(1, 4'b0001, 1, 0, 0, 2'd0, 2'd1, 0, 4);
    add(1, 4'b0010, 0, 0, 0, 2'd0, 2'd1, 0, 4);
    add(1, 4'b0100, 0, 0, 0, 2'd0, 2'd2, 0, 4);
    add(1, 4'b1000, 0, 0, 0, 2'd0, 2'd3, 0, 4);
    add(1, 4'b0001, 0, 1, 0, 2'd0, 2'd0, 0, 4);
    add(1, 4'b0010, 0, 1, 0, 2'd0, 2'd1, 0, 4);
    // Skip in LOCKED faults; clr_err outside FAULT is inert; skip in ACQUIRE restarts
    add(1, 4'b1000, 0, 0, 1, 2'd2, 2'd1, 0, 4);
    add(0, 4'b0000, 1, 0, 0, 2'd0, 2'd1, 0, 4);
    add(1, 4'b0001, 1, 0, 0, 2'd0, 2'd0, 0, 4);
    add(1, 4'b0010, 0, 0, 0, 2'd0, 2'd1, 0, 4);
    add(1, 4'b1000, 0, 0, 0, 2'd0, 2'd3, 0, 4);
    add(1, 4'b0001, 0, 0, 0, 2'd0, 2'd0, 0, 4);
    add(1, 4'b0010, 0, 0, 0, 2'd0, 2'd1, 0, 4);
    add(1, 4'b0100, 0, 1, 0, 2'd0, 2'd2, 0, 4);
    // Eight holds tolerated, then nine holds fault with stall code
    for (int k = 0; k < 8; k++) add(1, 4'b0100, 0, 1, 0, 2'd0, 2'd2, 0, 4);
    add(1, 4'b1000, 0, 1, 0, 2'd0, 2'd3, 0, 4);
    for (int k = 0; k < 8; k++) add(1, 4'b1000, 0, 1, 0, 2'd0, 2'd3, 0, 4);
    add(1, 4'b1000, 0, 0, 1, 2'd3, 2'd3, 0, 4);
    add(0, 4'b0000, 1, 0, 0, 2'd0, 2'd3, 0, 4);
    // Not-one-hot in ACQUIRE drops to IDLE without faulting
    add(1, 4'b0001, 0, 0, 0, 2'd0, 2'd0, 0, 4);
    add(1, 4'b0000, 0, 0, 0, 2'd0, 2'd0, 0, 4);
    add(1, 4'b0011, 0, 0, 0, 2'd0, 2'd0, 0, 4);
    add(1, 4'b0010, 0, 0, 0, 2'd0, 2'd1, 0, 4);
    add(1, 4'b0100, 0, 0, 0, 2'd0, 2'd2, 0, 4);
    add(1, 4'b1000, 0, 0, 0, 2'd0, 2'd3, 0, 4);
    add(1, 4'b0001, 0, 1, 0, 2'd0, 2'd0, 0, 4);
    add(1, 4'b0010, 0, 1, 0, 2'd0, 2'd1, 0, 4);
    add(1, 4'b0100, 0, 1, 0, 2'd0, 2'd2, 0, 4);
    add(1, 4'b1000, 0, 1, 0, 2'd0, 2'd3, 0, 4);
    add(1, 4'b0001, 0, 1, 0, 2'd0, 2'd0, 1, 5);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all(-1, 0, 0, 2'd0, 2'd0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].ph, vecs[i].clr);
      chk_all(i, vecs[i].lk, vecs[i].ft, vecs[i].err, vecs[i].idx, vecs[i].tick, vecs[i].rev);
    end

    // Asynchronous reset mid-LOCKED while phase_valid toggles
    step(0, 4'b0010, 0);
    chk_all(1000, 1, 0, 2'd0, 2'd0, 0, 5);
    @(negedge clk);
    phase_valid = 1'b1;
    phase_in    = 4'b0010;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_all(1001, 0, 0, 2'd0, 2'd0, 0, 0);
    @(negedge clk);
    phase_valid = 1'b0;
    @(negedge clk);
    phase_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_all(1002, 0, 0, 2'd0, 2'd0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    phase_valid = 1'b0;

    // Gapped acquisition still locks after the fourth legal sample
    step(1, 4'b0001, 0);
    step(0, 4'b1111, 0);
    step(1, 4'b0010, 0);
    step(0, 4'b0000, 0);
    step(0, 4'b0110, 0);
    step(1, 4'b0100, 0);
    chk_all(1003, 0, 0, 2'd0, 2'd2, 0, 0);
    step(0, 4'b1000, 0);
    chk_all(1004, 0, 0, 2'd0, 2'd2, 0, 0);
    step(1, 4'b1000, 0);
    chk_all(1005, 1, 0, 2'd0, 2'd3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
